periph_uart: RTL and testbench



---
 rtl/periph_uart.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_periph_uart.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_uart.sv
`default_nettype none
// ============================================================================
//  Module   : periph_uart
//  Purpose  : Memory-mapped 8N1 UART responder for the peripheral-side bus.
//             Byte FIFOs on both the TX and RX paths. Reads are answered
//             combinationally. A write is accepted on every cycle in which
//             WriteAssert_P is high.
//  Ports    : CoreClock      - single clock, rising edge
//             Reset          - synchronous, active-high
//             AddressBus_P   - word address, only [3:0] decoded
//             DataWriteBus_P - write data
//             WriteAssert_P  - write strobe, one write per cycle
//             DataReadBus_P  - combinational read data
//             UartTxD        - serial out (registered, idles high)
//             UartRxD        - serial in (asynchronous)
//             RxIrq          - registered, high while the RX FIFO holds data
//  Map      : 0 TXDATA, 1 RXDATA, 2 STATUS, 3 BAUD, 4..15 read 0
//  Revision : 1.0 - initial release
// ============================================================================
module periph_uart #(
    parameter int FIFO_DEPTH     = 8,
    parameter int BAUD_DIV_RESET = 433
) (
    input  logic        CoreClock,
    input  logic        Reset,
    input  logic [13:0] AddressBus_P,
    input  logic [31:0] DataWriteBus_P,
    input  logic        WriteAssert_P,
    output logic [31:0] DataReadBus_P,
    output logic        UartTxD,
    input  logic        UartRxD,
    output logic        RxIrq
);

    localparam int          c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_ptr_one = 1;
    localparam logic [15:0] c_baud_rst = 16'(BAUD_DIV_RESET);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Upper address bits alias and upper write-data bits are never used.
    logic w_unused;
    assign w_unused = ^{AddressBus_P[13:4], DataWriteBus_P[31:16]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0] w_addr;
    logic       w_wr_tx, w_wr_rx, w_wr_st, w_wr_baud;
    assign w_addr    = AddressBus_P[3:0];
    assign w_wr_tx   = WriteAssert_P && (w_addr == 4'd0);
    assign w_wr_rx   = WriteAssert_P && (w_addr == 4'd1);
    assign w_wr_st   = WriteAssert_P && (w_addr == 4'd2);
    assign w_wr_baud = WriteAssert_P && (w_addr == 4'd3);

    logic [15:0] r_baud;
    always_ff @(posedge CoreClock) begin
        if (Reset)          r_baud <= c_baud_rst;
        else if (w_wr_baud) r_baud <= DataWriteBus_P[15:0];
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [c_aw:0] r_tx_wptr, r_tx_rptr;
    logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_drop_set;
    logic [7:0]    w_tx_head;

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[c_aw] != r_tx_rptr[c_aw]) &&
                        (r_tx_wptr[c_aw-1:0] == r_tx_rptr[c_aw-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rptr[c_aw-1:0]];
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign w_tx_push     = w_wr_tx && (!w_tx_full || w_tx_pop);
    assign w_tx_drop_set = w_wr_tx && w_tx_full && !w_tx_pop;

    always_ff @(posedge CoreClock) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[c_aw-1:0]] <= DataWriteBus_P[7:0];
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_ptr_one;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_ptr_one;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    state_t      r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd;
    logic        w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == 16'd0);

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = S_START;
                end
            end
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = S_STOP;
            S_STOP: begin
                if (w_tx_tick) begin
                    // Chain straight into the next frame with no idle gap.
                    if (!w_tx_empty) begin
                        w_tx_pop  = 1'b1;
                        w_tx_next = S_START;
                    end else begin
                        w_tx_next = S_IDLE;
                    end
                end
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_div   <= r_baud;
                r_tx_cnt   <= r_baud;
                r_tx_bit   <= '0;
                r_txd      <= 1'b0;
            end else if (r_tx_state != S_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= r_tx_div;
                    case (r_tx_state)
                        S_START: r_txd <= r_tx_shift[0];
                        S_DATA: begin
                            // Drive the following bit; shift[1] becomes the
                            // new shift[0] after this edge.
                            if (r_tx_bit == 3'd7) begin
                                r_txd <= 1'b1;
                            end else begin
                                r_txd      <= r_tx_shift[1];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                            r_tx_bit <= r_tx_bit + 3'd1;
                        end
                        default: r_txd <= 1'b1;
                    endcase
                end else begin
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                end
            end
        end
    end

    assign UartTxD = r_txd;

    // ------------------------------------------------------------------
    // RX synchronizer and edge detect
    // ------------------------------------------------------------------
    logic r_rx_s1, r_rx_s2, r_rx_prev;
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= UartRxD;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    state_t      r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        w_rx_tick, w_rx_stop_ok, w_rx_ferr_set;

    assign w_rx_tick     = (r_rx_cnt == 16'd0);
    assign w_rx_stop_ok  = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;
    assign w_rx_ferr_set = (r_rx_state == S_STOP) && w_rx_tick && !r_rx_s2;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            // A falling edge needs prev=1, so after a bad stop bit the line
            // must return high before another frame can start.
            S_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = S_START;
            S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == S_IDLE) begin
                if (w_rx_next == S_START) begin
                    r_rx_div <= r_baud;
                    r_rx_cnt <= r_baud >> 1;   // first sample at mid start bit
                    r_rx_bit <= '0;
                end
            end else if (w_rx_tick) begin
                r_rx_cnt <= r_rx_div;
                if (r_rx_state == S_DATA) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [c_aw:0] r_rx_wptr, r_rx_rptr, w_rx_wptr_nxt, w_rx_rptr_nxt;
    logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr_set;
    logic [7:0]    w_rx_head;
    logic          r_irq;

    assign w_rx_empty    = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full     = (r_rx_wptr[c_aw] != r_rx_rptr[c_aw]) &&
                           (r_rx_wptr[c_aw-1:0] == r_rx_rptr[c_aw-1:0]);
    assign w_rx_head     = r_rx_mem[r_rx_rptr[c_aw-1:0]];
    assign w_rx_pop      = w_wr_rx && !w_rx_empty;
    assign w_rx_push     = w_rx_stop_ok && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set  = w_rx_stop_ok && w_rx_full && !w_rx_pop;
    assign w_rx_wptr_nxt = w_rx_push ? (r_rx_wptr + c_ptr_one) : r_rx_wptr;
    assign w_rx_rptr_nxt = w_rx_pop  ? (r_rx_rptr + c_ptr_one) : r_rx_rptr;

    always_ff @(posedge CoreClock) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[c_aw-1:0]] <= r_rx_shift;
    end

    // The interrupt is registered from next-state pointers so it tracks
    // FIFO occupancy without an extra cycle of lag.
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_rx_wptr <= w_rx_wptr_nxt;
            r_rx_rptr <= w_rx_rptr_nxt;
            r_irq     <= (w_rx_wptr_nxt != w_rx_rptr_nxt);
        end
    end

    assign RxIrq = r_irq;

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins.
    // ------------------------------------------------------------------
    logic r_rx_ovr, r_ferr, r_tx_drop;
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            r_rx_ovr  <= 1'b0;
            r_ferr    <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            if (w_rx_ovr_set)                        r_rx_ovr  <= 1'b1;
            else if (w_wr_st && DataWriteBus_P[4])   r_rx_ovr  <= 1'b0;
            if (w_rx_ferr_set)                       r_ferr    <= 1'b1;
            else if (w_wr_st && DataWriteBus_P[5])   r_ferr    <= 1'b0;
            if (w_tx_drop_set)                       r_tx_drop <= 1'b1;
            else if (w_wr_st && DataWriteBus_P[6])   r_tx_drop <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic w_tx_busy;
    assign w_tx_busy = !w_tx_empty || (r_tx_state != S_IDLE);

    always_comb begin
        DataReadBus_P = 32'd0;
        case (w_addr)
            4'd1: DataReadBus_P = {!w_rx_empty, 23'd0,
                                   (w_rx_empty ? 8'h00 : w_rx_head)};
            4'd2: DataReadBus_P = {25'd0, r_tx_drop, r_ferr, r_rx_ovr,
                                   w_rx_full, w_rx_empty, w_tx_full, w_tx_busy};
            4'd3: DataReadBus_P = {16'd0, r_baud};
            default: DataReadBus_P = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_uart.sv
`default_nettype none
// ============================================================================
//  Module   : tb_periph_uart
//  Purpose  : Directed self-checking bench for periph_uart (BAUD_DIV=3 so
//             one bit period is 4 clocks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_periph_uart;

    logic        CoreClock      = 1'b0;
    logic        Reset          = 1'b1;
    logic [13:0] AddressBus_P   = '0;
    logic [31:0] DataWriteBus_P = '0;
    logic        WriteAssert_P  = 1'b0;
    logic [31:0] DataReadBus_P;
    logic        UartTxD;
    logic        UartRxD        = 1'b1;
    logic        RxIrq;

    int errors = 0;
    int checks = 0;

    always #5 CoreClock = ~CoreClock;

    periph_uart #(.FIFO_DEPTH(8), .BAUD_DIV_RESET(433)) dut (
        .CoreClock      (CoreClock),
        .Reset          (Reset),
        .AddressBus_P   (AddressBus_P),
        .DataWriteBus_P (DataWriteBus_P),
        .WriteAssert_P  (WriteAssert_P),
        .DataReadBus_P  (DataReadBus_P),
        .UartTxD        (UartTxD),
        .UartRxD        (UartRxD),
        .RxIrq          (RxIrq)
    );

    // TX line recorder, one sample per cycle on the falling edge
    logic cap [0:1023];
    int   cap_n  = 0;
    logic cap_en = 1'b0;
    always @(negedge CoreClock) begin
        if (cap_en && cap_n < 1024) begin
            cap[cap_n] = UartTxD;
            cap_n = cap_n + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        AddressBus_P   = {10'h3A0, a};   // upper bits must be ignored
        DataWriteBus_P = d;
        WriteAssert_P  = 1'b1;
        @(negedge CoreClock);
        WriteAssert_P  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        AddressBus_P = {10'd0, a};
        #1;
        d = DataReadBus_P;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CoreClock);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        for (int i = 0; i < 10; i++) begin
            UartRxD = (i == 0) ? 1'b0 : (i == 9) ? stopb : b[i-1];
            repeat (4) @(negedge CoreClock);
        end
        UartRxD = 1'b1;
        repeat (12) @(negedge CoreClock);
    endtask

    task automatic wait_tx_idle(output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rd(4'd2, d);
            if (d[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge CoreClock);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic int find_start();
        for (int i = 0; i < cap_n; i++)
            if (cap[i] === 1'b0) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        Reset = 1'b1;
        cycles(3);
        Reset = 1'b0;
        cycles(1);
        rd(4'd2, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL reset_status got=%h exp=%h", d, 32'h4); end
        rd(4'd3, d); checks++;
        if (d !== 32'd433) begin errors++; $display("FAIL reset_baud got=%0d exp=433", d); end
        rd(4'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rxdata got=%h exp=0", d); end
        checks++;
        if (UartTxD !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", UartTxD); end
        checks++;
        if (RxIrq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", RxIrq); end
    endtask

    task automatic test_tx_single();
        logic [31:0] d;
        logic [43:0] got, exp;
        int s;
        wr(4'd3, 32'h3);
        rd(4'd3, d); checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL baud_write got=%h exp=3", d); end
        cap_n = 0; cap_en = 1'b1;
        wr(4'd0, 32'hA5);
        cycles(60);
        cap_en = 1'b0;
        rd(4'd2, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL tx_single_status got=%h exp=4", d); end
        s = find_start();
        checks++;
        if (s < 0 || s + 44 > cap_n) begin
            errors++; $display("FAIL tx_single_frame got=no_frame exp=frame_A5");
        end else begin
            for (int j = 0; j < 44; j++) begin
                got[j] = cap[s+j];
                exp[j] = (j < 40) ? frame_bit(8'hA5, j / 4) : 1'b1;
            end
            if (got !== exp) begin errors++; $display("FAIL tx_single_frame got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [39:0] got, exp;
        logic [3:0]  tail;
        bit ok;
        int s;
        cap_n = 0; cap_en = 1'b1;
        for (int i = 0; i < 9; i++) wr(4'd0, 32'(i));
        rd(4'd2, d); checks++;
        if (d !== 32'h7) begin errors++; $display("FAIL b2b_status got=%h exp=7", d); end
        cycles(380);
        cap_en = 1'b0;
        wait_tx_idle(ok); checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain got=busy exp=idle"); end
        s = find_start();
        checks++;
        if (s < 0 || s + 364 > cap_n) begin
            errors++; $display("FAIL b2b_capture got=%0d_samples exp=364", cap_n - s);
        end else begin
            for (int f = 0; f < 9; f++) begin
                for (int j = 0; j < 40; j++) begin
                    got[j] = cap[s + f*40 + j];
                    exp[j] = frame_bit(8'(f), j / 4);
                end
                checks++;
                if (got !== exp) begin errors++; $display("FAIL b2b_frame%0d got=%h exp=%h", f, got, exp); end
            end
            for (int j = 0; j < 4; j++) tail[j] = cap[s + 360 + j];
            if (tail !== 4'hF) begin errors++; $display("FAIL b2b_tail got=%b exp=1111", tail); end
        end
    endtask

    task automatic test_tx_drop();
        logic [31:0] d;
        logic [39:0] got, exp;
        logic [3:0]  tail;
        bit ok;
        int s;
        cap_n = 0; cap_en = 1'b1;
        for (int i = 0; i < 10; i++) wr(4'd0, 32'h10 + 32'(i));
        rd(4'd2, d); checks++;
        if (d !== 32'h47) begin errors++; $display("FAIL drop_status got=%h exp=47", d); end
        wr(4'd2, 32'h40);
        rd(4'd2, d); checks++;
        if (d !== 32'h07) begin errors++; $display("FAIL drop_clear got=%h exp=07", d); end
        cycles(380);
        cap_en = 1'b0;
        wait_tx_idle(ok); checks++;
        if (!ok) begin errors++; $display("FAIL drop_drain got=busy exp=idle"); end
        s = find_start();
        checks++;
        if (s < 0 || s + 364 > cap_n) begin
            errors++; $display("FAIL drop_capture got=%0d_samples exp=364", cap_n - s);
        end else begin
            for (int f = 0; f < 9; f++) begin
                for (int j = 0; j < 40; j++) begin
                    got[j] = cap[s + f*40 + j];
                    exp[j] = frame_bit(8'h10 + 8'(f), j / 4);
                end
                checks++;
                if (got !== exp) begin errors++; $display("FAIL drop_frame%0d got=%h exp=%h", f, got, exp); end
            end
            for (int j = 0; j < 4; j++) tail[j] = cap[s + 360 + j];
            if (tail !== 4'hF) begin errors++; $display("FAIL drop_tail got=%b exp=1111", tail); end
        end
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        send_rx(8'h3C, 1'b1);
        checks++;
        if (RxIrq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got=%b exp=1", RxIrq); end
        rd(4'd1, d); checks++;
        if (d !== 32'h8000003C) begin errors++; $display("FAIL rx_data got=%h exp=8000003c", d); end
        rd(4'd2, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rx_status got=%h exp=0", d); end
        wr(4'd1, 32'h0);
        rd(4'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rx_pop_data got=%h exp=0", d); end
        checks++;
        if (RxIrq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got=%b exp=0", RxIrq); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) send_rx(8'hA0 + 8'(i), 1'b1);
        rd(4'd2, d); checks++;
        if (d !== 32'h18) begin errors++; $display("FAIL ovr_status got=%h exp=18", d); end
        checks++;
        if (RxIrq !== 1'b1) begin errors++; $display("FAIL ovr_irq got=%b exp=1", RxIrq); end
        for (int i = 0; i < 8; i++) begin
            rd(4'd1, d); checks++;
            if (d !== (32'h80000000 | (32'hA0 + 32'(i)))) begin
                errors++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, d, 32'h80000000 | (32'hA0 + 32'(i)));
            end
            wr(4'd1, 32'h0);
        end
        rd(4'd2, d); checks++;
        if (d !== 32'h14) begin errors++; $display("FAIL ovr_drained got=%h exp=14", d); end
        wr(4'd2, 32'h10);
        rd(4'd2, d); checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL ovr_clear got=%h exp=04", d); end
        send_rx(8'h5A, 1'b0);
        rd(4'd2, d); checks++;
        if (d !== 32'h24) begin errors++; $display("FAIL ferr_status got=%h exp=24", d); end
        checks++;
        if (RxIrq !== 1'b0) begin errors++; $display("FAIL ferr_irq got=%b exp=0", RxIrq); end
        rd(4'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ferr_nopush got=%h exp=0", d); end
        wr(4'd2, 32'h20);
        rd(4'd2, d); checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL ferr_clear got=%h exp=04", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int zeros;
        send_rx(8'h77, 1'b1);
        checks++;
        if (RxIrq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq got=%b exp=1", RxIrq); end
        wr(4'd0, 32'h55);
        wr(4'd0, 32'h66);
        UartRxD = 1'b0;          // start bit of a frame that will be cut off
        cycles(10);
        Reset   = 1'b1;
        UartRxD = 1'b1;
        @(posedge CoreClock);
        #1;
        checks++;
        if (UartTxD !== 1'b1) begin errors++; $display("FAIL mid_txd got=%b exp=1", UartTxD); end
        @(negedge CoreClock);
        Reset = 1'b0;
        rd(4'd2, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mid_status got=%h exp=4", d); end
        rd(4'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_rxdata got=%h exp=0", d); end
        checks++;
        if (RxIrq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", RxIrq); end
        rd(4'd3, d); checks++;
        if (d !== 32'd433) begin errors++; $display("FAIL mid_baud got=%0d exp=433", d); end
        cap_n = 0; cap_en = 1'b1;
        cycles(60);
        cap_en = 1'b0;
        zeros = 0;
        for (int i = 0; i < cap_n; i++) if (cap[i] !== 1'b1) zeros++;
        checks++;
        if (zeros != 0) begin errors++; $display("FAIL mid_tx_quiet got=%0d_low_samples exp=0", zeros); end
        rd(4'd2, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mid_status_late got=%h exp=4", d); end
    endtask

    initial begin
        @(negedge CoreClock);
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_tx_drop();
        test_rx_single();
        test_rx_overrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
